// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the shared multicycle RV32I datapath
// Optional MULTICYCLE_MEM_WAIT_EN: FETCH, MEMREAD and MEMWRITE hold until mem_ready.
module multicycle_control #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pcwrite,
  output logic                 adrsrc,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic [1:0]           resultsrc,
  output logic [2:0]           alucontrol,
  output logic [1:0]           alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           immsrc,
  output logic                 regwrite,
  output logic                 illegal_op,
  output logic [3:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t     cur, nxt;
  logic [1:0] aluop;
  logic       pcupdate;
  logic       branch;
  logic       retire;
  logic       mem_go;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= S_FETCH;
      instret <= '0;
    end else begin
      cur <= nxt;
      if (retire)
        instret <= instret + INSTRET_W'(1);
    end
  end

  always_comb begin
    nxt        = S_FETCH;
    adrsrc     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    immsrc     = 2'b00;
    regwrite   = 1'b0;
    illegal_op = 1'b0;
    aluop      = 2'b00;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;
    case (cur)
      S_FETCH: begin
        irwrite   = mem_go;
        pcupdate  = mem_go;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        nxt       = mem_go ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded.
        alusrca = 2'b01;
        alusrcb = 2'b01;
        immsrc  = 2'b10;
        case (op)
          7'b0000011, 7'b0100011: nxt = S_MEMADR;
          7'b0110011:             nxt = S_EXECUTER;
          7'b0010011:             nxt = S_EXECUTEI;
          7'b1101111:             nxt = S_JAL;
          7'b1100011:             nxt = S_BEQ;
          default:                illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        immsrc  = op[5] ? 2'b01 : 2'b00;
        nxt     = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        nxt    = mem_go ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        retire   = mem_go;
        nxt      = mem_go ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
        nxt     = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
        nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        immsrc   = 2'b11;
        pcupdate = 1'b1;
        nxt      = S_ALUWB;
      end
      S_BEQ: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        immsrc  = 2'b10;
        branch  = 1'b1;
        retire  = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      2'b00: alucontrol = 3'b000;
      2'b01: alucontrol = 3'b001;
      default: begin
        case (funct3)
          // Only R-type (op[5]=1) turns funct7 into a subtract; addi never does.
          3'b000:  alucontrol = ({op[5], funct7} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
    endcase
  end

  assign pcwrite = pcupdate | (branch & zero);
  assign state   = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
// Optional MULTICYCLE_MEM_WAIT_EN adds a FETCH wait-state check.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic        zero;
  logic        mem_ready;
  logic        pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal_op;
  logic [1:0]  resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0]  alucontrol;
  logic [3:0]  state;
  logic [31:0] instret;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_instret = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [18:0] outs;
    logic [31:0] ir;
  } exp_t;

  exp_t sb[$];

  multicycle_control #(.INSTRET_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .pcwrite(pcwrite), .adrsrc(adrsrc),
    .memwrite(memwrite), .irwrite(irwrite), .resultsrc(resultsrc),
    .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb),
    .immsrc(immsrc), .regwrite(regwrite), .illegal_op(illegal_op),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic legal_op(input logic [6:0] o);
    return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
           (o == 7'b0010011) || (o == 7'b1101111) || (o == 7'b1100011);
  endfunction

  // Expected control word: {pcw,adr,mw,irw,rs,alu,sa,sb,imm,rw,ill}
  function automatic logic [18:0] model(input logic [3:0] st, input logic [6:0] o,
                                        input logic [2:0] f3, input logic f7, input logic z);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] rs = 0, sa = 0, srcb = 0, imm = 0;
    logic [2:0] alu = 0, rdec;
    case (f3)
      3'd0:    rdec = (o[5] && f7) ? 3'b001 : 3'b000;
      3'd2:    rdec = 3'b101;
      3'd6:    rdec = 3'b011;
      3'd7:    rdec = 3'b010;
      default: rdec = 3'b000;
    endcase
    case (st)
      4'd0:  begin pcw = 1; irw = 1; srcb = 2'b10; rs = 2'b10; end
      4'd1:  begin sa = 2'b01; srcb = 2'b01; imm = 2'b10; ill = !legal_op(o); end
      4'd2:  begin sa = 2'b10; srcb = 2'b01; imm = o[5] ? 2'b01 : 2'b00; end
      4'd3:  adr = 1;
      4'd4:  begin rs = 2'b01; rw = 1; end
      4'd5:  begin adr = 1; mw = 1; end
      4'd6:  begin sa = 2'b10; alu = rdec; end
      4'd7:  rw = 1;
      4'd8:  begin sa = 2'b10; srcb = 2'b01; alu = rdec; end
      4'd9:  begin sa = 2'b01; srcb = 2'b10; pcw = 1; imm = 2'b11; end
      4'd10: begin sa = 2'b10; alu = 3'b001; imm = 2'b10; pcw = z; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rs, alu, sa, srcb, imm, rw, ill};
  endfunction

  task automatic push_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    int seq[$];
    case (o)
      7'b0000011: seq = '{0, 1, 2, 3, 4};
      7'b0100011: seq = '{0, 1, 2, 5};
      7'b0110011: seq = '{0, 1, 6, 7};
      7'b0010011: seq = '{0, 1, 8, 7};
      7'b1101111: seq = '{0, 1, 9, 7};
      7'b1100011: seq = '{0, 1, 10};
      default:    seq = '{0, 1};
    endcase
    foreach (seq[i])
      sb.push_back('{st: 4'(seq[i]), outs: model(4'(seq[i]), o, f3, f7, z), ir: 32'(exp_instret)});
    if (legal_op(o))
      exp_instret++;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    exp_t e;
    op = o; funct3 = f3; funct7 = f7; zero = z;
    push_instr(o, f3, f7, z);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("state op=%b", o), 32'(state), 32'(e.st));
      check($sformatf("outs op=%b st=%0d", o, e.st),
            32'({pcwrite, adrsrc, memwrite, irwrite, resultsrc, alucontrol,
                 alusrca, alusrcb, immsrc, regwrite, illegal_op}), 32'(e.outs));
      check($sformatf("instret op=%b st=%0d", o, e.st), instret, e.ir);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b1;
    op = 7'b0; funct3 = 3'b0; funct7 = 1'b0; zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset state", 32'(state), 32'd0);
    check("reset irwrite", 32'(irwrite), 32'd1);
    check("reset pcwrite", 32'(pcwrite), 32'd1);
    check("reset regwrite", 32'(regwrite), 32'd0);
    check("reset memwrite", 32'(memwrite), 32'd0);
    check("reset instret", instret, 32'd0);
    reset = 1'b0;

`ifdef MULTICYCLE_MEM_WAIT_EN
    mem_ready = 1'b0;
    repeat (2) begin
      check("wait state", 32'(state), 32'd0);
      check("wait irwrite", 32'(irwrite), 32'd0);
      check("wait pcwrite", 32'(pcwrite), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    mem_ready = 1'b1;
`endif

    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0);  // lw
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0);  // sw
    run_instr(7'b0110011, 3'd0, 1'b0, 1'b0);  // add
    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0);  // sub
    run_instr(7'b0010011, 3'd0, 1'b1, 1'b0);  // addi with bit30 set
    run_instr(7'b0110011, 3'd2, 1'b0, 1'b0);  // slt
    run_instr(7'b0010011, 3'd6, 1'b0, 1'b0);  // ori
    run_instr(7'b0110011, 3'd7, 1'b0, 1'b0);  // and
    run_instr(7'b0110011, 3'd4, 1'b0, 1'b0);  // unsupported funct3 -> add
    run_instr(7'b1101111, 3'd0, 1'b0, 1'b0);  // jal
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b1);  // beq taken
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b0);  // beq not taken
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b0);  // illegal
    run_instr(7'b0000000, 3'd0, 1'b0, 1'b0);  // illegal

    op = 7'b0000011;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midreset pre state", 32'(state), 32'd2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset state", 32'(state), 32'd0);
    check("midreset instret", instret, 32'd0);
    exp_instret = 0;
    reset = 1'b0;

    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0);  // sw after reset
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0);  // lw after reset

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences the shared multicycle RV32I datapath: one ALU, one unified instruction/data memory, one register file.
- Reuses the single-cycle decode encodings for alucontrol, immsrc and resultsrc, but spreads each instruction over 3-5 states.
- Sits beside the datapath and drives every enable and mux select each cycle.
- Also keeps a retired-instruction counter and flags unsupported opcodes.

Parameters:
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  7  opcode field, taken from the instruction register.
- funct3  in  3  funct3 field.
- funct7  in  1  instruction bit 30 (funct7[5]).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle (used only with MEM_WAIT_EN).
- pcwrite  out  1  PC register enable.
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register / OldPC enable.
- resultsrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult.
- alucontrol  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- alusrca  out  2  ALU A select: 00 PC, 01 OldPC, 10 RD1.
- alusrcb  out  2  ALU B select: 00 RD2, 01 ImmExt, 10 constant 4.
- immsrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- regwrite  out  1  register file write enable.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state  out  4  current state encoding, for debug.
- instret  out  INSTRET_W  count of retired instructions.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10. Encodings 11-15 are unused and go to FETCH on the next edge.
- Reset:
  - Registered: state<=FETCH, instret<=0.
  - Outputs are Moore decodes of state, so while reset is high they show the FETCH values.
  - Reset mid-instruction abandons the instruction; no partial retire is counted.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ; any other op -> FETCH with illegal_op=1.
  - MEMADR -> MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECUTER, EXECUTEI, JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
- Per-state outputs (anything not listed is 0):
  - FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, alucontrol=add, resultsrc=10, pcupdate=1.
  - DECODE: alusrca=01, alusrcb=01, alucontrol=add, immsrc=10 (branch target precompute).
  - MEMADR: alusrca=10, alusrcb=01, alucontrol=add; immsrc=01 if op[5] else 00.
  - MEMREAD: resultsrc=00, adrsrc=1.
  - MEMWB: resultsrc=01, regwrite=1.
  - MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1.
  - EXECUTER: alusrca=10, alusrcb=00, aluop=10.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=10, immsrc=00.
  - ALUWB: resultsrc=00, regwrite=1.
  - JAL: alusrca=01, alusrcb=10, alucontrol=add, resultsrc=00, pcupdate=1, immsrc=11.
  - BEQ: alusrca=10, alusrcb=00, alucontrol=sub, resultsrc=00, branch=1, immsrc=10.
- pcwrite = pcupdate | (branch & zero), combinational from the current cycle's zero.
- ALU decode when aluop=10, by funct3:
  - 000: sub if {op[5],funct7}=11, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Anything else: add.
- Retire counting:
  - instret increments by 1 on the clock edge leaving MEMWB, MEMWRITE, ALUWB or BEQ.
  - It wraps modulo 2^INSTRET_W.
  - Illegal opcodes are not counted.

Optional Feature:
- Macro: MULTICYCLE_MEM_WAIT_EN.
- Defined: FETCH, MEMREAD and MEMWRITE each hold their state until mem_ready=1.
  - FETCH: irwrite and pcwrite are asserted only in the cycle mem_ready=1.
  - MEMWRITE: memwrite stays high for every cycle of the hold.
  - Reset during a hold returns to FETCH.
- Undefined: mem_ready is ignored; every state lasts exactly one cycle.

Test Plan:
- Reset held 3 cycles, then released -> state=0, instret=0, irwrite=1, pcwrite=1, regwrite=0, memwrite=0.
- lw (op=0000011) -> state sequence 0,1,2,3,4,0 (5 cycles); regwrite=1 only in state 4; instret 0->1.
- sw (op=0100011) -> sequence 0,1,2,5,0; memwrite=1 only in state 5 with adrsrc=1; MEMADR shows immsrc=01.
- R-type sub (op=0110011, funct3=000, funct7=1) -> EXECUTER alucontrol=001; add (funct7=0) -> 000; I-type addi with funct7=1 -> 000.
- beq in state 10: zero=1 -> pcwrite=1; zero=0 -> pcwrite=0. Both take 3 cycles and increment instret.
- op=1111111 -> illegal_op=1 for one cycle in DECODE, then FETCH; instret unchanged.
- MULTICYCLE_MEM_WAIT_EN defined, mem_ready low 2 cycles in FETCH -> state stays 0, irwrite=0 until mem_ready=1.
